// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle for the multicycle RV32I core.
//   master : the controller (drives control selects/enables, reads fields/flags/ready)
//   slave  : the datapath + memory side
// Signals:
//   opcode/funct3     latched instruction fields
//   zero_flag/sign_flag ALU flags, meaningful in the branch state
//   mem_ready         memory finishes the current access this cycle
//   mem_req/mem_write/adr_src  memory port control
//   ir_write/pc_write/reg_write  datapath write enables
//   alu_src_a/alu_src_b/alu_op/result_src/imm_src  datapath selects
//   instr_done/illegal_op  one-cycle status pulses
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero_flag;
  logic       sign_flag;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, funct3, zero_flag, sign_flag, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           instr_done, illegal_op
  );

  modport slave (
    output opcode, funct3, zero_flag, sign_flag, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src,
           instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM of the multicycle RV32I core. Sequences a shared ALU and a
// unified instruction/data memory port, resolves branches, and stalls on
// mem_ready at every memory state.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; forces every output to 0 while high
//   bus  multicycle_controller_if.master (fields/flags/ready in, controls out)
// Parameters:
//   STATE_W  state register width (holds all state codes)
// Build option:
//   MULTICYCLE_JAL_EN  adds the JAL state; otherwise opcode 1101111 is illegal.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  multicycle_controller_if.master  bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ
`ifdef MULTICYCLE_JAL_EN
    , S_JAL
`endif
  } state_t;

  // Field order matches the output concatenation below.
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  state_t state, state_nxt;
  ctrl_t  c;
  logic   taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    unique case (bus.funct3)
      3'b000:  taken = bus.zero_flag;
      3'b001:  taken = ~bus.zero_flag;
      3'b100:  taken = bus.sign_flag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    c         = '0;
    state_nxt = state;
    case (state)
      S_FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.ir_write   = bus.mem_ready;
        c.pc_write   = bus.mem_ready;
        if (bus.mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes OldPC + imm (branch/jump target) here.
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        case (bus.opcode)
          OP_STORE: c.imm_src = 2'b01;
          OP_BR:    c.imm_src = 2'b10;
          OP_JAL:   c.imm_src = 2'b11;
          default:  c.imm_src = 2'b00;
        endcase
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXECR;
          OP_I:              state_nxt = S_EXECI;
          OP_BR:             state_nxt = S_BEQ;
`ifdef MULTICYCLE_JAL_EN
          OP_JAL:            state_nxt = S_JAL;
`endif
          default: begin
            state_nxt    = S_FETCH;
            c.illegal_op = 1'b1;
            c.instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.imm_src   = bus.opcode[5] ? 2'b01 : 2'b00;
        state_nxt   = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
        if (bus.mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe only on the completing cycle so a stall never writes.
        c.mem_req    = 1'b1;
        c.adr_src    = 1'b1;
        c.mem_write  = bus.mem_ready;
        c.instr_done = bus.mem_ready;
        if (bus.mem_ready) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
        state_nxt   = S_ALUWB;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BEQ: begin
        c.alu_src_a  = 2'b10;
        c.alu_op     = 2'b01;
        c.imm_src    = 2'b10;
        c.instr_done = 1'b1;
        c.pc_write   = taken;
        state_nxt    = S_FETCH;
      end
`ifdef MULTICYCLE_JAL_EN
      S_JAL: begin
        // PC <- target held in ALUOut; ALU forms OldPC + 4 for rd.
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.imm_src   = 2'b11;
        c.pc_write  = 1'b1;
        state_nxt   = S_ALUWB;
      end
`endif
      default: state_nxt = S_FETCH;
    endcase
  end

  // Reset masks outputs combinationally: state is already FETCH, but no
  // request or enable may leave the block while rst is high.
  assign {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
          bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
          bus.result_src, bus.imm_src, bus.instr_done, bus.illegal_op}
         = rst ? '0 : c;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core. Sequences one shared ALU and one unified instruction/data memory port over several clock cycles per instruction. Drives the datapath mux selects and write enables from a registered state and the latched opcode/funct fields. Resolves branches, and stalls on a memory ready/valid handshake.

## Interface
Parameters:
- `STATE_W`, default 4: width of the state register; must hold all 11 state codes.

Ports:
- `clk`  in  1: single clock. All state changes occur on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `opcode`  in  7: instruction[6:0], taken from the instruction register.
- `funct3`  in  3: instruction[14:12].
- `zero_flag`, `sign_flag`  in  1 each: ALU flags, valid in the BEQ state.
- `mem_ready`  in  1: memory completes the current access this cycle.
- `mem_req`  out  1: memory access request.
- `mem_write`  out  1: memory write strobe.
- `adr_src`  out  1: memory address select. 0 = PC, 1 = ALUOut.
- `ir_write`  out  1: load the instruction register and OldPC.
- `pc_write`  out  1: load the PC.
- `reg_write`  out  1: register file write enable.
- `alu_src_a`  out  2: ALU operand A select. 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b`  out  2: ALU operand B select. 00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op`  out  2: 00 = add, 01 = sub/compare, 10 = decode from funct fields.
- `result_src`  out  2: result mux select. 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `imm_src`  out  2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `instr_done`  out  1: one-cycle pulse on the last cycle of each instruction.
- `illegal_op`  out  1: one-cycle pulse when Decode sees an unsupported opcode.

## Operation
States:
- FETCH
- DECODE
- MEMADR
- MEMREAD
- MEMWB
- MEMWRITE
- EXECR
- EXECI
- ALUWB
- BEQ
- JAL (JAL exists only under the macro; see Configuration)

Outputs are a Moore decode of the state, with two exceptions: `mem_ready`, `zero_flag` and `sign_flag` gate the enables as listed below. Any select not listed for a state is 00.

Per-state outputs and transitions:
- **FETCH**
  - Outputs: `mem_req=1`, `adr_src=0`, `alu_src_a=00`, `alu_src_b=10`, `result_src=10`, `ir_write=mem_ready`, `pc_write=mem_ready`.
  - Transition: to DECODE when `mem_ready`; otherwise hold.
- **DECODE**
  - Outputs: `alu_src_a=01`, `alu_src_b=01`, `alu_op=00` (precomputes the branch target).
  - `imm_src` by opcode: 0100011 → 01, 1100011 → 10, 1101111 → 11, otherwise 00.
  - Next state by opcode: 0000011 or 0100011 → MEMADR, 0110011 → EXECR, 0010011 → EXECI, 1100011 → BEQ.
  - Any other opcode → FETCH, with `illegal_op=1` and `instr_done=1`.
- **MEMADR**
  - Outputs: `alu_src_a=10`, `alu_src_b=01`; `imm_src=01` if opcode[5]=1, else 00.
  - Next state: MEMWRITE if opcode[5]=1, else MEMREAD.
- **MEMREAD**
  - Outputs: `mem_req=1`, `adr_src=1`.
  - Transition: to MEMWB when `mem_ready`; otherwise hold.
- **MEMWB**
  - Outputs: `result_src=01`, `reg_write=1`, `instr_done=1`.
  - Next state: FETCH.
- **MEMWRITE**
  - Outputs: `mem_req=1`, `adr_src=1`, `mem_write=mem_ready`.
  - `instr_done=mem_ready`.
  - Transition: to FETCH when `mem_ready`; otherwise hold.
- **EXECR**
  - Outputs: `alu_src_a=10`, `alu_src_b=00`, `alu_op=10`.
  - Next state: ALUWB.
- **EXECI**
  - Outputs: `alu_src_a=10`, `alu_src_b=01`, `alu_op=10`.
  - Next state: ALUWB.
- **ALUWB**
  - Outputs: `result_src=00`, `reg_write=1`, `instr_done=1`.
  - Next state: FETCH.
- **BEQ**
  - Outputs: `alu_src_a=10`, `alu_src_b=00`, `alu_op=01`, `imm_src=10`, `instr_done=1`.
  - `pc_write` = taken, where taken is: funct3 000 → `zero_flag`; 001 → `~zero_flag`; 100 → `sign_flag`; any other funct3 → 0.
  - Next state: FETCH.

Boundary conditions:
- A `mem_ready` stall may last any number of cycles. While stalled, outputs stay stable and no write enable asserts.
- Reset mid-instruction aborts the instruction immediately: no partial `reg_write` or `mem_write` is issued.

## Timing
- Reset:
  - `state=FETCH`.
  - While `rst=1`, every output is 0, including `mem_req`.
  - The first `mem_req=1` occurs in the first cycle after `rst` falls.
- Cycles per instruction with `mem_ready` tied high:
  - lw: 5
  - sw: 4
  - R-type and I-type: 4
  - branch: 3
  - jal: 4
  - illegal opcode: 2
- Each wait cycle at a memory state adds exactly 1 cycle.
- The state register is the only storage. Outputs are combinational from the state and inputs, with no added latency.

## Configuration
- Macro `MULTICYCLE_JAL_EN`.
- Defined:
  - DECODE sends opcode 1101111 to the JAL state.
  - JAL outputs: `alu_src_a=01`, `alu_src_b=10`, `alu_op=00`, `result_src=00`, `imm_src=11`, `pc_write=1` (PC ← ALUOut target; the return address OldPC+4 is computed).
  - JAL next state: ALUWB, which writes rd.
- Undefined:
  - The JAL state is absent.
  - Opcode 1101111 is illegal: DECODE pulses `illegal_op`.

## Test plan
- Reset held 3 cycles mid-MEMREAD, then released → all outputs 0 during reset; cycle 1 after release is FETCH with `mem_req=1`.
- add (0110011), `mem_ready=1` → states FETCH, DECODE, EXECR, ALUWB; `reg_write=1` only in cycle 4; `instr_done` in cycle 4.
- lw (0000011) with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; `result_src=01` and `reg_write=1` in the last cycle; `mem_write` never asserts.
- sw (0100011) → `mem_write=1` exactly once, with `adr_src=1`; `imm_src=01` in DECODE and MEMADR.
- Branch sweep:
  - beq, `zero_flag=1` → `pc_write=1` in BEQ.
  - bne, `zero_flag=1` → `pc_write=0`.
  - blt (funct3 100), `sign_flag=1` → `pc_write=1`.
  - funct3 010 → `pc_write=0`.
- Opcode 1101111:
  - With `MULTICYCLE_JAL_EN` → FETCH, DECODE, JAL, ALUWB; `pc_write` in the JAL state.
  - Without → `illegal_op` pulse in DECODE, then FETCH.
